instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Sequential fetch/issue engine that produces the 60-bit instruction stream, and therefore the 4-bit opcode, consumed by the opcode decoder (Control_Unit). It holds the PC and fetches one instruction at a time over a valid/ready instruction-memory interface. It presents each instruction downstream and takes the decoder's `branch_en`/`jump_en` back to redirect the PC. Non-pipelined: one instruction in flight.

## Interface
Parameters:
- `ADDR_W`, 16: PC / instruction-memory word-address width.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `run`  in  1  level enable; fetching proceeds while high.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_addr`  out  ADDR_W  word address of request (= PC).
- `imem_rsp_valid`  in  1  response data valid.
- `imem_rsp_data`  in  60  fetched instruction.
- `inst_out`  out  60  held instruction.
- `opcode`  out  4  `inst_out[59:56]`, drives the decoder.
- `inst_pc`  out  ADDR_W  PC of held instruction.
- `inst_valid`  out  1  instruction presented downstream.
- `inst_ready`  in  1  downstream accepts instruction.
- `branch_en`  in  1  decoder output for `opcode`.
- `jump_en`  in  1  decoder output for `opcode`.
- `br_resolve_valid`  in  1  branch outcome available.
- `br_taken`  in  1  branch outcome; sampled with `br_resolve_valid`.

## Operation
- Instruction fields:
  - opcode `[59:56]`.
  - branch offset `[15:0]`, signed two's-complement words.
  - jump target `[ADDR_W-1:0]`, absolute.
- FSM states: IDLE, REQ, RSP, ISSUE, RESOLVE.
- IDLE: all valids low; `run`=1 → REQ.
- REQ: `imem_req_valid`=1, `imem_addr`=PC held stable until `imem_req_ready`; handshake → RSP.
- RSP: wait `imem_rsp_valid`; capture data into instruction register and PC into `inst_pc` → ISSUE.
- ISSUE: `inst_valid`=1; `inst_out` stable until `inst_ready`. On handshake, sample `branch_en`/`jump_en`:
  - `jump_en`=1 → PC = jump target.
  - else `branch_en`=1 → RESOLVE, PC unchanged.
  - else PC = PC+1.
  - Jump has priority if both are asserted.
- RESOLVE: wait `br_resolve_valid`. PC = `inst_pc` + sext(offset) if `br_taken`, else `inst_pc`+1.
- After ISSUE (non-branch) or RESOLVE: `run`=1 → REQ, `run`=0 → IDLE.
- `run` is sampled only at those exits and in IDLE; an in-progress fetch always completes.
- PC arithmetic is modulo 2^ADDR_W: PC+1 at all-ones wraps to 0; negative offsets wrap the same way.
- Inputs are ignored outside their state:
  - `imem_rsp_valid` outside RSP.
  - `br_resolve_valid` outside RESOLVE.
  - `branch_en`/`jump_en` outside an ISSUE handshake.

## Timing
- Reset values, all outputs:
  - PC = `RESET_PC`, state IDLE.
  - `imem_req_valid`=0, `inst_valid`=0.
  - `imem_addr`=`RESET_PC`, `inst_pc`=0.
  - `inst_out`=60'h0 with opcode forced to 4'b0011 (register op, decoder outputs all 0), so `opcode`=4'b0011.
- Reset asserted mid-operation aborts immediately to reset values; an in-flight memory response is dropped.
- Best case per sequential instruction: 3 cycles. REQ accepted in cycle 1, response in cycle 2, issue accepted in cycle 3.
- A branch adds at least 1 cycle (RESOLVE).
- Redirected fetch address appears on `imem_addr` in the cycle after the ISSUE or RESOLVE handshake.
- All outputs are registered or decoded from state; no combinational path from `inst_ready` to `imem_req_valid`.
- `branch_en`/`jump_en` is a combinational round trip through the decoder from `opcode`; it is sampled in the same cycle.

## Structure
- Shared package `cpu_pkg`:
  - `INST_W`=60.
  - opcode constants `OP_BRANCH`=4'b0000, `OP_JUMP`=4'b0001, `OP_IMM`=4'b0010, `OP_REG`=4'b0011.
  - field position constants.
  - fetch FSM state enum.
- One natural sub-module: `fetch_pc_gen`, a combinational next-PC select/add (PC+1, branch target, jump target) with wrap.

## Test plan
- Straight line: memory returns `OP_REG` words at 0,1,2 with zero wait, `inst_ready`=1 → `imem_addr` 0,1,2, one `inst_valid` every 3 cycles.
- Jump: word at 5 = `OP_JUMP`, target 0x0040 → next `imem_addr`=0x0040 the cycle after the issue handshake.
- Branch: word at 0x10 = `OP_BRANCH`, offset 0xFFFC.
  - `br_taken`=1 → next fetch 0x000C.
  - repeat with `br_taken`=0 → 0x0011.
  - `br_resolve_valid` delayed 4 cycles → no request during the wait.
- Backpressure: `imem_req_ready` low 3 cycles, `inst_ready` low 2 cycles → address and `inst_out` stable, no duplicate fetch.
- Wrap: PC=0xFFFF non-branch → next 0x0000; `run` dropped during RSP → instruction still issued, then IDLE with no request.
- Reset mid-RSP → outputs return to reset values asynchronously; the late `imem_rsp_valid` is ignored; `opcode`=4'b0011.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction-format constants and fetch-unit enums
package cpu_pkg;
    localparam int INST_W = 60;
    localparam logic [3:0] OP_BRANCH = 4'b0000;
    localparam logic [3:0] OP_JUMP   = 4'b0001;
    localparam logic [3:0] OP_IMM    = 4'b0010;
    localparam logic [3:0] OP_REG    = 4'b0011;
    localparam int OPC_MSB = 59;
    localparam int OPC_LSB = 56;
    localparam int OFF_MSB = 15;
    localparam int OFF_LSB = 0;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RSP, S_ISSUE, S_RESOLVE} fetch_state_e;
    typedef enum logic [1:0] {SEL_INC, SEL_JUMP, SEL_BRANCH} pc_sel_e;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory request/response bus
interface instr_fetch_unit_if #(parameter int ADDR_W = 16);
    import cpu_pkg::*;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    modport master(output imem_req_valid, imem_addr, input imem_req_ready, imem_rsp_valid, imem_rsp_data);
    modport slave(input imem_req_valid, imem_addr, output imem_req_ready, imem_rsp_valid, imem_rsp_data);
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: next-PC select (sequential, branch target, jump target), modulo 2^ADDR_W
module fetch_pc_gen import cpu_pkg::*; #(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] base_i,
    input  logic [15:0]       off_i,
    input  logic [ADDR_W-1:0] target_i,
    input  pc_sel_e           sel_i,
    output logic [ADDR_W-1:0] next_pc_o
);
    localparam int EXT_W = ADDR_W > 16 ? ADDR_W : 16;
    logic [EXT_W-1:0] off_ext;
    // sign-extend the word offset and pick the redirect source; adds wrap naturally
    always_comb begin
        off_ext   = EXT_W'(signed'(off_i));
        next_pc_o = sel_i == SEL_JUMP ? target_i :
                    sel_i == SEL_BRANCH ? base_i + off_ext[ADDR_W-1:0] : base_i + ADDR_W'(1);
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: non-pipelined fetch/issue engine with decoder-driven PC redirect
module instr_fetch_unit import cpu_pkg::*; #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    instr_fetch_unit_if.master  imem,
    output logic [INST_W-1:0]   inst_out,
    output logic [3:0]          opcode,
    output logic [ADDR_W-1:0]   inst_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    input  logic                branch_en,
    input  logic                jump_en,
    input  logic                br_resolve_valid,
    input  logic                br_taken
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, inst_pc_q, inst_pc_d, next_pc;
    logic [INST_W-1:0] inst_q, inst_d;
    pc_sel_e           sel;

    fetch_pc_gen #(.ADDR_W(ADDR_W)) u_pc_gen (
        .base_i   (inst_pc_q),
        .off_i    (inst_q[OFF_MSB:OFF_LSB]),
        .target_i (inst_q[ADDR_W-1:0]),
        .sel_i    (sel),
        .next_pc_o(next_pc)
    );

    assign imem.imem_req_valid = state_q == S_REQ;
    assign imem.imem_addr      = pc_q;
    assign inst_valid          = state_q == S_ISSUE;
    assign inst_out            = inst_q;
    assign opcode              = inst_q[OPC_MSB:OPC_LSB];
    assign inst_pc             = inst_pc_q;

    // state, PC and held instruction; reset leaves a harmless register-op in the decoder
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            inst_pc_q <= '0;
            inst_q    <= {OP_REG, {(INST_W-4){1'b0}}};
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_pc_q <= inst_pc_d;
            inst_q    <= inst_d;
        end
    end

    // fetch sequencing; jump wins over branch, branches park in RESOLVE until the outcome arrives
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_pc_d = inst_pc_q;
        inst_d    = inst_q;
        sel       = state_q == S_RESOLVE ? (br_taken ? SEL_BRANCH : SEL_INC) : (jump_en ? SEL_JUMP : SEL_INC);
        case (state_q)
            S_IDLE: state_d = run ? S_REQ : S_IDLE;
            S_REQ:  state_d = imem.imem_req_ready ? S_RSP : S_REQ;
            S_RSP: begin
                if (imem.imem_rsp_valid) begin
                    inst_d    = imem.imem_rsp_data;
                    inst_pc_d = pc_q;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (inst_ready) begin
                    if (!jump_en && branch_en) begin
                        state_d = S_RESOLVE;
                    end else begin
                        pc_d    = next_pc;
                        state_d = run ? S_REQ : S_IDLE;
                    end
                end
            end
            S_RESOLVE: begin
                if (br_resolve_valid) begin
                    pc_d    = next_pc;
                    state_d = run ? S_REQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench with a zero-wait memory and opcode decoder model
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        inst_ready = 1'b0;
    logic        br_resolve_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic [59:0] inst_out;
    logic [3:0]  opcode;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic        branch_en, jump_en;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          force_rsp = 1'b0;
    logic [59:0] mem [logic [15:0]];
    logic [15:0] fetch_q [$];
    int          iss_cyc [$];
    logic [59:0] iss_data [$];

    instr_fetch_unit_if #(.ADDR_W(16)) imem ();

    instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .run(run), .imem(imem),
        .inst_out(inst_out), .opcode(opcode), .inst_pc(inst_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .branch_en(branch_en), .jump_en(jump_en),
        .br_resolve_valid(br_resolve_valid), .br_taken(br_taken)
    );

    assign branch_en = opcode == OP_BRANCH;
    assign jump_en   = opcode == OP_JUMP;

    always #5 clk = ~clk;

    function automatic logic [59:0] mem_rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : {OP_REG, 40'h0, a};
    endfunction

    initial begin
        logic        hs;
        logic [15:0] a;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            hs = imem.imem_req_valid && imem.imem_req_ready && !rst;
            a  = imem.imem_addr;
            @(posedge clk);
            #1;
            imem.imem_rsp_valid = hs || force_rsp;
            imem.imem_rsp_data  = hs ? mem_rd(a) : 60'h1AAAAAAAAAAAAAA;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst && imem.imem_req_valid && imem.imem_req_ready) fetch_q.push_back(imem.imem_addr);
            if (!rst && inst_valid && inst_ready) begin
                iss_cyc.push_back(cyc);
                iss_data.push_back(inst_out);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        run = 1'b0;
        imem.imem_req_ready = 1'b0;
        inst_ready = 1'b0;
        br_resolve_valid = 1'b0;
        br_taken = 1'b0;
        force_rsp = 1'b0;
        mem.delete();
        tick;
        tick;
        rst = 1'b0;
        fetch_q.delete();
        iss_cyc.delete();
        iss_data.delete();
    endtask

    task automatic go;
        run = 1'b1;
        imem.imem_req_ready = 1'b1;
        inst_ready = 1'b1;
    endtask

    task automatic wait_issue(input logic [15:0] pc, output bit found);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (inst_valid && inst_pc == pc) found = 1'b1;
            else tick;
        end
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (imem.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem.imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        checks++; if (imem.imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", imem.imem_addr); end
        checks++; if (inst_pc !== 16'h0000) begin errors++; $display("FAIL reset_inst_pc: got %h want 0000", inst_pc); end
        checks++; if (opcode !== 4'b0011) begin errors++; $display("FAIL reset_opcode: got %b want 0011", opcode); end
        checks++; if (inst_out !== {4'b0011, 56'h0}) begin errors++; $display("FAIL reset_inst_out: got %h want %h", inst_out, {4'b0011, 56'h0}); end
        tick;
        tick;
        checks++; if (imem.imem_req_valid !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b want 0", imem.imem_req_valid); end
    endtask

    task automatic test_straight;
        do_reset;
        go;
        for (int i = 0; i < 60 && iss_cyc.size() < 3; i++) tick;
        checks++;
        if (iss_cyc.size() < 3) begin
            errors++; $display("FAIL straight_timeout: got %0d issues want 3", iss_cyc.size());
        end else begin
            checks++; if (fetch_q[0] !== 16'h0000) begin errors++; $display("FAIL straight_addr0: got %h want 0000", fetch_q[0]); end
            checks++; if (fetch_q[1] !== 16'h0001) begin errors++; $display("FAIL straight_addr1: got %h want 0001", fetch_q[1]); end
            checks++; if (fetch_q[2] !== 16'h0002) begin errors++; $display("FAIL straight_addr2: got %h want 0002", fetch_q[2]); end
            checks++; if (iss_cyc[1] - iss_cyc[0] !== 3) begin errors++; $display("FAIL straight_rate01: got %0d want 3", iss_cyc[1] - iss_cyc[0]); end
            checks++; if (iss_cyc[2] - iss_cyc[1] !== 3) begin errors++; $display("FAIL straight_rate12: got %0d want 3", iss_cyc[2] - iss_cyc[1]); end
            checks++; if (iss_data[1] !== {OP_REG, 40'h0, 16'h0001}) begin errors++; $display("FAIL straight_data1: got %h want %h", iss_data[1], {OP_REG, 40'h0, 16'h0001}); end
        end
        run = 1'b0;
    endtask

    task automatic test_jump;
        bit found;
        do_reset;
        mem[16'h0005] = {OP_JUMP, 40'h0, 16'h0040};
        go;
        wait_issue(16'h0005, found);
        checks++; if (!found) begin errors++; $display("FAIL jump_issue_timeout: got none want pc 0005"); end
        checks++; if (opcode !== OP_JUMP) begin errors++; $display("FAIL jump_opcode: got %b want 0001", opcode); end
        checks++; if (fetch_q.size() !== 6) begin errors++; $display("FAIL jump_fetch_count: got %0d want 6", fetch_q.size()); end
        tick;
        checks++; if (imem.imem_addr !== 16'h0040) begin errors++; $display("FAIL jump_target: got %h want 0040", imem.imem_addr); end
        checks++; if (imem.imem_req_valid !== 1'b1) begin errors++; $display("FAIL jump_req_valid: got %b want 1", imem.imem_req_valid); end
        run = 1'b0;
    endtask

    task automatic test_branch(input logic taken, input int delay, input logic [15:0] exp);
        bit found;
        int n;
        do_reset;
        mem[16'h0000] = {OP_JUMP, 40'h0, 16'h0010};
        mem[16'h0010] = {OP_BRANCH, 40'h0, 16'hFFFC};
        go;
        wait_issue(16'h0010, found);
        checks++; if (!found) begin errors++; $display("FAIL branch_issue_timeout: got none want pc 0010"); end
        n = fetch_q.size();
        tick;
        for (int i = 0; i < delay; i++) begin
            checks++; if (imem.imem_req_valid !== 1'b0) begin errors++; $display("FAIL branch_wait_req: got %b want 0 (cycle %0d)", imem.imem_req_valid, i); end
            tick;
        end
        br_resolve_valid = 1'b1;
        br_taken = taken;
        tick;
        br_resolve_valid = 1'b0;
        checks++; if (imem.imem_addr !== exp) begin errors++; $display("FAIL branch_target: got %h want %h", imem.imem_addr, exp); end
        checks++; if (imem.imem_req_valid !== 1'b1) begin errors++; $display("FAIL branch_req_valid: got %b want 1", imem.imem_req_valid); end
        checks++; if (fetch_q.size() !== n) begin errors++; $display("FAIL branch_no_fetch: got %0d want %0d", fetch_q.size(), n); end
        run = 1'b0;
    endtask

    task automatic test_backpressure;
        do_reset;
        run = 1'b1;
        tick;
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem.imem_req_valid !== 1'b1) begin errors++; $display("FAIL bp_req_valid: got %b want 1", imem.imem_req_valid); end
            checks++; if (imem.imem_addr !== 16'h0000) begin errors++; $display("FAIL bp_addr: got %h want 0000", imem.imem_addr); end
            tick;
        end
        checks++; if (fetch_q.size() !== 0) begin errors++; $display("FAIL bp_early_fetch: got %0d want 0", fetch_q.size()); end
        imem.imem_req_ready = 1'b1;
        tick;
        imem.imem_req_ready = 1'b0;
        tick;
        for (int i = 0; i < 2; i++) begin
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_inst_valid: got %b want 1", inst_valid); end
            checks++; if (inst_out !== {OP_REG, 40'h0, 16'h0000}) begin errors++; $display("FAIL bp_inst_out: got %h want %h", inst_out, {OP_REG, 40'h0, 16'h0000}); end
            checks++; if (imem.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_during_issue: got %b want 0", imem.imem_req_valid); end
            tick;
        end
        inst_ready = 1'b1;
        tick;
        checks++; if (imem.imem_addr !== 16'h0001) begin errors++; $display("FAIL bp_next_addr: got %h want 0001", imem.imem_addr); end
        checks++; if (fetch_q.size() !== 1) begin errors++; $display("FAIL bp_dup_fetch: got %0d want 1", fetch_q.size()); end
        checks++; if (iss_data.size() !== 1) begin errors++; $display("FAIL bp_dup_issue: got %0d want 1", iss_data.size()); end
        run = 1'b0;
    endtask

    task automatic test_wrap;
        bit found;
        int n;
        do_reset;
        mem[16'h0000] = {OP_JUMP, 40'h0, 16'hFFFF};
        go;
        wait_issue(16'hFFFF, found);
        checks++; if (!found) begin errors++; $display("FAIL wrap_issue_timeout: got none want pc ffff"); end
        tick;
        checks++; if (imem.imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr: got %h want 0000", imem.imem_addr); end
        checks++; if (imem.imem_req_valid !== 1'b1) begin errors++; $display("FAIL wrap_req_valid: got %b want 1", imem.imem_req_valid); end
        tick;
        run = 1'b0;
        tick;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stop_still_issues: got %b want 1", inst_valid); end
        checks++; if (inst_pc !== 16'h0000) begin errors++; $display("FAIL stop_inst_pc: got %h want 0000", inst_pc); end
        tick;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stop_idle_valid: got %b want 0", inst_valid); end
        n = fetch_q.size();
        tick;
        tick;
        tick;
        checks++; if (imem.imem_req_valid !== 1'b0) begin errors++; $display("FAIL stop_idle_req: got %b want 0", imem.imem_req_valid); end
        checks++; if (fetch_q.size() !== n) begin errors++; $display("FAIL stop_no_fetch: got %0d want %0d", fetch_q.size(), n); end
    endtask

    task automatic test_reset_mid_rsp;
        bit found;
        do_reset;
        mem[16'h0000] = {OP_JUMP, 40'h0, 16'h0020};
        go;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (imem.imem_req_valid && imem.imem_addr == 16'h0020) found = 1'b1;
            else tick;
        end
        checks++; if (!found) begin errors++; $display("FAIL rst_req_timeout: got none want addr 0020"); end
        tick;
        checks++; if (opcode !== OP_JUMP) begin errors++; $display("FAIL rst_pre_opcode: got %b want 0001", opcode); end
        #2;
        rst = 1'b1;
        force_rsp = 1'b1;
        run = 1'b0;
        #1;
        checks++; if (imem.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_async_req: got %b want 0", imem.imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", inst_valid); end
        checks++; if (imem.imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_async_addr: got %h want 0000", imem.imem_addr); end
        checks++; if (opcode !== 4'b0011) begin errors++; $display("FAIL rst_async_opcode: got %b want 0011", opcode); end
        tick;
        rst = 1'b0;
        tick;
        tick;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_late_rsp_valid: got %b want 0", inst_valid); end
        checks++; if (opcode !== 4'b0011) begin errors++; $display("FAIL rst_late_rsp_opcode: got %b want 0011", opcode); end
        checks++; if (imem.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_late_req: got %b want 0", imem.imem_req_valid); end
        force_rsp = 1'b0;
    endtask

    initial begin
        imem.imem_req_ready = 1'b0;
        test_reset;
        test_straight;
        test_jump;
        test_branch(1'b1, 4, 16'h000C);
        test_branch(1'b0, 0, 16'h0011);
        test_backpressure;
        test_wrap;
        test_reset_mid_rsp;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
